// File: rtl/fetch_sequencer_pkg.sv
// ============================================================================
//  fetch_sequencer_pkg : shared fetch constants, state encoding, PC helpers
//  Revision: 1.0
// ============================================================================
`default_nettype none

package fetch_sequencer_pkg;

   typedef enum logic [1:0] {
      FETCH_BOOT = 2'd0,
      FETCH_RUN  = 2'd1,
      FETCH_HALT = 2'd2
   } fetch_state_t;

   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
   localparam logic [31:0] PC_INC           = 32'd4;

   function automatic logic [31:0] align_word(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_sequencer_perf_counter.sv
// ============================================================================
//  perf_counter : 32-bit event counter, sync active-low reset, wraps at 2^32
//  Revision: 1.0
// ============================================================================
`default_nettype none

module perf_counter (
   input  logic        clk,
   input  logic        rst,
   input  logic        inc,
   output logic [31:0] count
);

   always_ff @(posedge clk) begin
      if (!rst) begin
         count <= 32'd0;
      end else if (inc) begin
         count <= count + 32'd1;
      end
   end

endmodule

`default_nettype wire

// File: rtl/fetch_sequencer.sv
// ============================================================================
//  fetch_sequencer : drives the 1-cycle synchronous instruction ROM, owns the
//  fetch PC, applies redirects/halt/stall. Optional FETCH_PERF_EN adds counters.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module fetch_sequencer
   import fetch_sequencer_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
   parameter int          XLEN     = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall_i,
   input  logic            redirect_valid_i,
   input  logic [XLEN-1:0] redirect_pc_i,
   input  logic            halt_i,
   output logic [XLEN-1:0] imem_addr_o,
   output logic            imem_en_o,
   input  logic [XLEN-1:0] imem_dout_i,
   output logic            if_valid_o,
   output logic [XLEN-1:0] if_pc_o,
   output logic [XLEN-1:0] if_instr_o,
   output logic            misalign_o
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0]     fetch_count_o,
   output logic [31:0]     kill_count_o
`endif
);

   fetch_state_t state;
   logic [31:0]  fetch_pc;
   logic [31:0]  resp_pc;
   logic         resp_valid;
   logic [31:0]  redirect_target;
   logic         halted;

   assign redirect_target = align_word(redirect_pc_i);
   assign halted          = (state == FETCH_HALT);

   always_comb begin
      imem_addr_o = fetch_pc;
      imem_en_o   = 1'b0;
      if (!rst) begin
         imem_en_o = 1'b0;
      end else if (redirect_valid_i) begin
         imem_addr_o = redirect_target;
         imem_en_o   = 1'b1;
      end else if (!halted && !halt_i && !stall_i) begin
         imem_en_o = 1'b1;
      end
   end

   // A redirect in flight kills whatever word is currently sitting on dout.
   assign if_valid_o = rst & resp_valid & ~redirect_valid_i & ~halted;
   assign if_pc_o    = resp_pc;
   assign if_instr_o = imem_dout_i;
   assign misalign_o = rst & redirect_valid_i & (redirect_pc_i[1:0] != 2'b00);

   always_ff @(posedge clk) begin
      if (!rst) begin
         fetch_pc   <= RESET_PC;
         resp_pc    <= 32'd0;
         resp_valid <= 1'b0;
         state      <= FETCH_BOOT;
      end else if (redirect_valid_i) begin
         fetch_pc   <= redirect_target + PC_INC;
         resp_pc    <= redirect_target;
         resp_valid <= 1'b1;
         state      <= FETCH_RUN;
      end else if (halted) begin
         state      <= FETCH_HALT;
      end else if (halt_i) begin
         resp_valid <= 1'b0;
         state      <= FETCH_HALT;
      end else if (!stall_i) begin
         fetch_pc   <= fetch_pc + PC_INC;
         resp_pc    <= fetch_pc;
         resp_valid <= 1'b1;
         state      <= FETCH_RUN;
      end
   end

`ifdef FETCH_PERF_EN
   perf_counter u_fetch_count (
      .clk   (clk),
      .rst   (rst),
      .inc   (if_valid_o & ~stall_i),
      .count (fetch_count_o)
   );

   perf_counter u_kill_count (
      .clk   (clk),
      .rst   (rst),
      .inc   (redirect_valid_i & resp_valid),
      .count (kill_count_o)
   );
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
// ============================================================================
//  tb_fetch_sequencer : randomized + directed bench for fetch_sequencer with a
//  transaction-level reference model and a behavioural synchronous ROM.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_fetch_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall_i;
   logic        redirect_valid_i;
   logic [31:0] redirect_pc_i;
   logic        halt_i;
   logic [31:0] imem_addr_o;
   logic        imem_en_o;
   logic [31:0] imem_dout_i;
   logic        if_valid_o;
   logic [31:0] if_pc_o;
   logic [31:0] if_instr_o;
   logic        misalign_o;
`ifdef FETCH_PERF_EN
   logic [31:0] fetch_count_o;
   logic [31:0] kill_count_o;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   fetch_sequencer #(
      .RESET_PC (32'h0000_0000),
      .XLEN     (32)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .stall_i          (stall_i),
      .redirect_valid_i (redirect_valid_i),
      .redirect_pc_i    (redirect_pc_i),
      .halt_i           (halt_i),
      .imem_addr_o      (imem_addr_o),
      .imem_en_o        (imem_en_o),
      .imem_dout_i      (imem_dout_i),
      .if_valid_o       (if_valid_o),
      .if_pc_o          (if_pc_o),
      .if_instr_o       (if_instr_o),
      .misalign_o       (misalign_o)
`ifdef FETCH_PERF_EN
      ,
      .fetch_count_o    (fetch_count_o),
      .kill_count_o     (kill_count_o)
`endif
   );

   function automatic logic [31:0] rom_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   // ROM: 1-cycle read latency, dout holds when not enabled
   always @(posedge clk) begin
      if (imem_en_o) imem_dout_i <= rom_word(imem_addr_o);
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference model: next address to issue, the one outstanding response, halt flag
   logic [31:0] m_next_pc;
   logic [31:0] m_pend_pc;
   bit          m_pend_v;
   bit          m_halted;
   bit          m_init = 1'b0;
   logic [31:0] m_fetch_cnt;
   logic [31:0] m_kill_cnt;
   int          n_valid = 0;

   task automatic step(input bit r, input bit s, input bit rv, input logic [31:0] rpc, input bit h);
      bit          e_en;
      bit          e_valid;
      bit          e_mis;
      logic [31:0] e_addr;
      @(negedge clk);
      rst              = r;
      stall_i          = s;
      redirect_valid_i = rv;
      redirect_pc_i    = rpc;
      halt_i           = h;
      #1;
      e_addr = m_next_pc;
      e_mis  = 1'b0;
      if (!r) begin
         e_en    = 1'b0;
         e_valid = 1'b0;
      end else if (rv) begin
         e_en    = 1'b1;
         e_addr  = rpc & 32'hFFFF_FFFC;
         e_valid = 1'b0;
         e_mis   = (rpc % 4) != 0;
      end else begin
         e_en    = !m_halted && !h && !s;
         e_valid = m_pend_v && !m_halted;
      end
      check_val("imem_en", {31'd0, imem_en_o}, {31'd0, e_en});
      check_val("if_valid", {31'd0, if_valid_o}, {31'd0, e_valid});
      check_val("misalign", {31'd0, misalign_o}, {31'd0, e_mis});
      if (r && m_init) check_val("imem_addr", imem_addr_o, e_addr);
      if (e_valid) begin
         check_val("if_pc", if_pc_o, m_pend_pc);
         check_val("if_instr", if_instr_o, rom_word(m_pend_pc));
         n_valid++;
      end
`ifdef FETCH_PERF_EN
      if (r && m_init) begin
         check_val("fetch_count", fetch_count_o, m_fetch_cnt);
         check_val("kill_count", kill_count_o, m_kill_cnt);
      end
`endif
      @(posedge clk);
      if (!r) begin
         m_next_pc   = 32'h0000_0000;
         m_pend_pc   = 32'd0;
         m_pend_v    = 1'b0;
         m_halted    = 1'b0;
         m_init      = 1'b1;
         m_fetch_cnt = 32'd0;
         m_kill_cnt  = 32'd0;
      end else begin
         if (e_valid && !s) m_fetch_cnt = m_fetch_cnt + 1;
         if (rv && m_pend_v) m_kill_cnt = m_kill_cnt + 1;
         if (rv) begin
            m_pend_pc = e_addr;
            m_next_pc = e_addr + 4;
            m_pend_v  = 1'b1;
            m_halted  = 1'b0;
         end else if (m_halted) begin
            m_halted = 1'b1;
         end else if (h) begin
            m_pend_v = 1'b0;
            m_halted = 1'b1;
         end else if (!s) begin
            m_pend_pc = m_next_pc;
            m_next_pc = m_next_pc + 4;
            m_pend_v  = 1'b1;
         end
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
   endtask

   initial begin
      rst              = 1'b0;
      stall_i          = 1'b0;
      redirect_valid_i = 1'b0;
      redirect_pc_i    = 32'd0;
      halt_i           = 1'b0;

      // Directed: reset, stall, redirect, redirect+stall, misaligned, halt, wrap, mid-run reset
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
      run(3);
      step(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
      run(4);
      step(1'b1, 1'b0, 1'b1, 32'd64, 1'b0);
      run(3);
      step(1'b1, 1'b1, 1'b1, 32'd12, 1'b0);
      run(2);
      step(1'b1, 1'b0, 1'b1, 32'h0000_0042, 1'b0);
      run(2);
      step(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
      run(5);
      step(1'b1, 1'b1, 1'b0, 32'd0, 1'b1);
      step(1'b1, 1'b0, 1'b1, 32'd4, 1'b1);
      run(3);
      step(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
      run(3);
      step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
      run(3);

      // Randomized traffic
      for (int i = 0; i < 800; i++) begin
         bit          r;
         bit          s;
         bit          rv;
         bit          h;
         logic [31:0] rpc;
         r  = ($urandom_range(0, 99) >= 2);
         s  = ($urandom_range(0, 99) < 20);
         rv = ($urandom_range(0, 99) < 10);
         h  = ($urandom_range(0, 99) < 4);
         case ($urandom_range(0, 3))
            0:       rpc = 32'hFFFF_FFFC;
            1:       rpc = $urandom_range(0, 255);
            2:       rpc = {$urandom_range(0, 1023), 2'b00};
            default: rpc = $urandom;
         endcase
         step(r, s, rv, rpc, h);
      end

      checks++;
      if (n_valid < 100) begin
         errors++;
         $display("FAIL valid_traffic observed=%0d expected>=%0d", n_valid, 100);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
